// File: rtl/sweep_limit_counter.sv
// rtl/sweep_limit_counter.sv - prescaled sweep-limit counter (optional down-count via SWEEP_DIR_EN)
module sweep_limit_counter #(
    parameter int WIDTH    = 9,
    parameter int PRESCALE = 1,
    parameter int PS_WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             CLR,
    input  logic             MODE,
`ifdef SWEEP_DIR_EN
    input  logic             DIR,
`endif
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] COUNT,
    output logic             CNT_ACTIVE,
    output logic             DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]    ONE     = WIDTH'(1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    lim_q, lim_d;
    logic [PS_WIDTH-1:0] ps_q, ps_d;
    logic                mode_q, mode_d;
    logic                dir_q, dir_d;
    logic                done_q, done_d;
    logic                active_q, active_d;

    logic                dir_in;
    logic                tick;
    logic [WIDTH-1:0]    lim_acc;

`ifdef SWEEP_DIR_EN
    assign dir_in = DIR;
`else
    assign dir_in = 1'b0;
`endif

    // A limit of zero would never terminate, so it is treated as one.
    assign lim_acc = (LIMIT == '0) ? ONE : LIMIT;
    assign tick    = (ps_q == PS_LAST);

    // Next-state, count, prescaler and output computation.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        lim_d    = lim_q;
        ps_d     = ps_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        active_d = 1'b0;

        if (CLR) begin
            // Clear beats enable and any terminal tick in the same cycle.
            state_d = ST_IDLE;
            count_d = '0;
            ps_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (EN) begin
                        lim_d    = lim_acc;
                        mode_d   = MODE;
                        dir_d    = dir_in;
                        ps_d     = '0;
                        state_d  = ST_RUN;
                        active_d = 1'b1;
                        count_d  = dir_in ? lim_acc : '0;
                    end
                end

                ST_RUN: begin
                    if (!EN) begin
                        // Abort: no DONE even when a tick lands on the limit.
                        state_d = ST_IDLE;
                        count_d = '0;
                        ps_d    = '0;
                    end else begin
                        active_d = 1'b1;
                        ps_d     = tick ? '0 : ps_q + PS_WIDTH'(1);
                        if (tick) begin
                            if (!dir_q) begin
                                if (count_q == lim_q) begin
                                    // Only reachable in continuous mode: wrap.
                                    count_d = '0;
                                end else if (count_q == lim_q - ONE) begin
                                    count_d = lim_q;
                                    done_d  = 1'b1;
                                    if (!mode_q) begin
                                        state_d  = ST_HOLD;
                                        active_d = 1'b0;
                                    end
                                end else begin
                                    count_d = count_q + ONE;
                                end
                            end else begin
                                if (count_q == '0) begin
                                    // Continuous down-count reloads the limit.
                                    count_d = lim_q;
                                end else if (count_q == ONE) begin
                                    count_d = '0;
                                    done_d  = 1'b1;
                                    if (!mode_q) begin
                                        state_d  = ST_HOLD;
                                        active_d = 1'b0;
                                    end
                                end else begin
                                    count_d = count_q - ONE;
                                end
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    // Holding enable high never restarts; it must drop first.
                    if (!EN) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    ps_d    = '0;
                end
            endcase
        end
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            lim_q    <= '0;
            ps_q     <= '0;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lim_q    <= lim_d;
            ps_q     <= ps_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    assign COUNT      = count_q;
    assign CNT_ACTIVE = active_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_sweep_limit_counter.sv
// tb/tb_sweep_limit_counter.sv - directed self-checking bench for sweep_limit_counter
module tb_sweep_limit_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       mode;
    logic       dir;
    logic [8:0] limit;
    logic [8:0] count_a, count_b;
    logic       active_a, active_b;
    logic       done_a, done_b;

    int n_cmp = 0;
    int n_err = 0;

    sweep_limit_counter #(.WIDTH(9), .PRESCALE(1), .PS_WIDTH(8)) dut_a (
        .CLK(clk), .RST_N(rst_n), .EN(en), .CLR(clr), .MODE(mode),
`ifdef SWEEP_DIR_EN
        .DIR(dir),
`endif
        .LIMIT(limit), .COUNT(count_a), .CNT_ACTIVE(active_a), .DONE(done_a)
    );

    sweep_limit_counter #(.WIDTH(9), .PRESCALE(3), .PS_WIDTH(8)) dut_b (
        .CLK(clk), .RST_N(rst_n), .EN(en), .CLR(clr), .MODE(mode),
`ifdef SWEEP_DIR_EN
        .DIR(dir),
`endif
        .LIMIT(limit), .COUNT(count_b), .CNT_ACTIVE(active_b), .DONE(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int c, input int act, input int dn);
        check_eq({tag, " count"},  32'(count_a),  32'(c));
        check_eq({tag, " active"}, 32'(active_a), 32'(act));
        check_eq({tag, " done"},   32'(done_a),   32'(dn));
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 1'b0; dir = 1'b0; limit = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        check_a("reset", 0, 0, 0);

        // One-shot, PRESCALE=1, LIMIT=5
        limit = 9'd5; mode = 1'b0; en = 1'b1;
        step();
        check_a("os e0", 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_a("os run", i, (i < 5) ? 1 : 0, (i == 5) ? 1 : 0);
        end
        step();
        check_a("os hold1", 5, 0, 0);
        step();
        check_a("os hold2", 5, 0, 0);
        en = 1'b0;
        step();
        check_a("os idle", 0, 0, 0);
        step();

        // Continuous, PRESCALE=3, LIMIT=2 (dut_b)
        limit = 9'd2; mode = 1'b1; en = 1'b1;
        step();
        check_eq("ct e0 active", 32'(active_b), 32'd1);
        check_eq("ct e0 count",  32'(count_b),  32'd0);
        for (int e = 1; e <= 15; e++) begin
            step();
            check_eq("ct count",  32'(count_b),  32'((e / 3) % 3));
            check_eq("ct done",   32'(done_b),   32'((e == 6 || e == 15) ? 1 : 0));
            check_eq("ct active", 32'(active_b), 32'd1);
        end
        en = 1'b0; mode = 1'b0;
        step();
        check_eq("ct idle count", 32'(count_b), 32'd0);

        // Abort at COUNT=4, then restart with a new limit
        limit = 9'd10; en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        check_a("ab pre", 4, 1, 0);
        en = 1'b0;
        step();
        check_a("ab post", 0, 0, 0);
        limit = 9'd3; en = 1'b1;
        step();
        check_a("ab restart", 0, 1, 0);
        limit = 9'd7;
        step(); step(); step();
        check_a("ab newlim", 3, 0, 1);
        en = 1'b0;
        step();

        // Abort coinciding with the terminal tick
        limit = 9'd3; en = 1'b1;
        step(); step(); step();
        check_a("abt pre", 2, 1, 0);
        en = 1'b0;
        step();
        check_a("abt post", 0, 0, 0);

        // LIMIT=0 behaves as LIMIT=1
        limit = 9'd0; en = 1'b1;
        step();
        check_a("l0 e0", 0, 1, 0);
        step();
        check_a("l0 e1", 1, 0, 1);
        en = 1'b0;
        step();

        // LIMIT=511 reaches full scale without wrapping
        limit = 9'd511; en = 1'b1;
        step();
        dones = 0;
        for (int i = 1; i <= 510; i++) begin
            step();
            check_eq("l511 count", 32'(count_a), 32'(i));
            if (done_a) dones = dones + 1;
        end
        step();
        check_a("l511 end", 511, 0, 1);
        dones = dones + 1;
        step();
        check_a("l511 hold", 511, 0, 0);
        check_eq("l511 dones", 32'(dones), 32'd1);
        en = 1'b0;
        step();

        // CLR coinciding with terminal tick
        limit = 9'd2; en = 1'b1;
        step(); step();
        check_a("clr pre", 1, 1, 0);
        clr = 1'b1;
        step();
        check_a("clr post", 0, 0, 0);
        clr = 1'b0; en = 1'b0;
        step();

        // Asynchronous reset mid-run at COUNT=3
        limit = 9'd10; en = 1'b1;
        step(); step(); step(); step();
        check_a("rst pre", 3, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("rst async", 0, 0, 0);
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_a("rst after", 0, 0, 0);

`ifdef SWEEP_DIR_EN
        // Down-count, one-shot, LIMIT=4
        dir = 1'b1; limit = 9'd4; mode = 1'b0; en = 1'b1;
        step();
        check_a("dn e0", 4, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_a("dn run", 4 - i, (i < 4) ? 1 : 0, (i == 4) ? 1 : 0);
        end
        step();
        check_a("dn hold", 0, 0, 0);
        en = 1'b0; dir = 1'b0;
        step();
        check_a("dn idle", 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
